// File: rtl/mseq_pkg.sv
// Shared definitions for the ARC microprogram sequencer: COND encodings,
// microword field offsets (relative to ADDR_W) and default parameter values.
package mseq_pkg;

    localparam int MSEQ_ADDR_W     = 11;
    localparam int MSEQ_WORD_W     = 41;
    localparam int MSEQ_RESET_ADDR = 0;
    localparam int MSEQ_TRAP_ADDR  = 2047;

    // Field offsets above the JUMP field; absolute bit = ADDR_W + offset
    localparam int COND_OFS = 0;
    localparam int COND_W   = 3;
    localparam int ALU_OFS  = 3;
    localparam int ALU_W    = 4;
    localparam int WR_OFS   = 7;
    localparam int RD_OFS   = 8;

    localparam int COND_LSB_DEF = MSEQ_ADDR_W + COND_OFS;
    localparam int ALU_LSB_DEF  = MSEQ_ADDR_W + ALU_OFS;
    localparam int WR_BIT_DEF   = MSEQ_ADDR_W + WR_OFS;
    localparam int RD_BIT_DEF   = MSEQ_ADDR_W + RD_OFS;

    typedef enum logic [2:0] {
        COND_NEXT   = 3'b000,
        COND_N      = 3'b001,
        COND_Z      = 3'b010,
        COND_V      = 3'b011,
        COND_C      = 3'b100,
        COND_IR13   = 3'b101,
        COND_JUMP   = 3'b110,
        COND_DECODE = 3'b111
    } cond_e;

endpackage

// File: rtl/micro_store.sv
// Microprogram control store with two read ports (MPC and decode probe).
// Unpopulated addresses return the fetch microword with hit = 0.
module micro_store
    import mseq_pkg::*;
#(
    parameter int ADDR_W = MSEQ_ADDR_W,
    parameter int WORD_W = MSEQ_WORD_W
) (
    input  logic [ADDR_W-1:0] addr_a,
    output logic [WORD_W-1:0] word_a,
    output logic              hit_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [WORD_W-1:0] word_b,
    output logic              hit_b
);

    function automatic logic [WORD_W-1:0] mw(input cond_e c, input logic [31:0] j,
                                             input logic [ALU_W-1:0] alu,
                                             input logic rd, input logic wr);
        logic [WORD_W-1:0] w;
        w = '0;
        w[ADDR_W-1:0] = j[ADDR_W-1:0];
        w[ADDR_W+COND_OFS +: COND_W] = c;
        w[ADDR_W+ALU_OFS +: ALU_W] = alu;
        w[ADDR_W+WR_OFS] = wr;
        w[ADDR_W+RD_OFS] = rd;
        return w;
    endfunction

    // Returns {hit, word}
    function automatic logic [WORD_W:0] lookup(input logic [ADDR_W-1:0] addr);
        logic [31:0]     a;
        logic [WORD_W:0] r;
        a = 32'(addr);
        r[WORD_W] = 1'b1;
        case (a)
            32'd0:    r[WORD_W-1:0] = mw(COND_NEXT,   32'd0,    4'd0, 1'b1, 1'b0);
            32'd1:    r[WORD_W-1:0] = mw(COND_DECODE, 32'd0,    4'd0, 1'b0, 1'b0);
            32'd8:    r[WORD_W-1:0] = mw(COND_IR13,   32'd12,   4'd0, 1'b0, 1'b0);
            32'd9, 32'd12, 32'd1606:
                      r[WORD_W-1:0] = mw(COND_JUMP,   32'd0,    4'd0, 1'b0, 1'b0);
            32'd20:   r[WORD_W-1:0] = mw(COND_JUMP,   32'd8,    4'd0, 1'b0, 1'b0);
            32'd40, 32'd41, 32'd42, 32'd43:
                      r[WORD_W-1:0] = mw(COND_NEXT,   32'd0,    4'd2, 1'b0, 1'b0);
            32'd44:   r[WORD_W-1:0] = mw(COND_JUMP,   32'd2047, 4'd0, 1'b0, 1'b1);
            32'd1600, 32'd1601:
                      r[WORD_W-1:0] = mw(COND_NEXT,   32'd0,    4'd1, 1'b0, 1'b0);
            32'd1602: r[WORD_W-1:0] = mw(COND_N,      32'd20,   4'd0, 1'b0, 1'b0);
            32'd1603: r[WORD_W-1:0] = mw(COND_Z,      32'd20,   4'd0, 1'b0, 1'b0);
            32'd1604: r[WORD_W-1:0] = mw(COND_V,      32'd20,   4'd0, 1'b0, 1'b0);
            32'd1605: r[WORD_W-1:0] = mw(COND_C,      32'd20,   4'd0, 1'b0, 1'b0);
            32'd1808: r[WORD_W-1:0] = mw(COND_NEXT,   32'd0,    4'd3, 1'b1, 1'b0);
            32'd1809: r[WORD_W-1:0] = mw(COND_JUMP,   32'd40,   4'd0, 1'b0, 1'b0);
            32'd2047: r[WORD_W-1:0] = mw(COND_NEXT,   32'd0,    4'd0, 1'b0, 1'b0);
            default:  r = {1'b0, mw(COND_NEXT, 32'd0, 4'd0, 1'b1, 1'b0)};
        endcase
        return r;
    endfunction

    // MPC read port
    always_comb begin
        {hit_a, word_a} = lookup(addr_a);
    end

    // Decode probe read port
    always_comb begin
        {hit_b, word_b} = lookup(addr_b);
    end

endmodule

// File: rtl/micro_sequencer.sv
// ARC microprogram sequencer: MPC register, next-address selection, decode trap.
// Optional MSEQ_MEMWAIT_EN: RD/WR microwords stall until MSEQ_MemAck_In.
module micro_sequencer
    import mseq_pkg::*;
#(
    parameter int ADDR_W     = MSEQ_ADDR_W,
    parameter int WORD_W     = MSEQ_WORD_W,
    parameter int RESET_ADDR = MSEQ_RESET_ADDR,
    parameter int TRAP_ADDR  = MSEQ_TRAP_ADDR
) (
    input  logic              MSEQ_CLOCK_50,
    input  logic              MSEQ_RESET_InLow,
    input  logic              MSEQ_Run_In,
    input  logic [31:0]       MSEQ_IR_In,
    input  logic [3:0]        MSEQ_PSR_In,
    input  logic              MSEQ_MemAck_In,
    output logic [WORD_W-1:0] MSEQ_MIR_Out,
    output logic [ADDR_W-1:0] MSEQ_MPC_Out,
    output logic              MSEQ_Illegal_Out
);

    localparam int COND_LSB = ADDR_W + COND_OFS;
    localparam int WR_BIT   = ADDR_W + WR_OFS;
    localparam int RD_BIT   = ADDR_W + RD_OFS;

    logic [ADDR_W-1:0] mpc_r;
    logic              illegal_r;
    logic [WORD_W-1:0] mir_s;
    logic              mir_hit_s;
    logic [WORD_W-1:0] probe_word_s;
    logic              probe_hit_s;
    logic [ADDR_W-1:0] decode_addr_s;
    logic [ADDR_W-1:0] next_mpc_s;
    cond_e             cond_s;
    logic              cond_true_s;
    logic              set_illegal_s;
    logic              mem_wait_s;
    logic              hold_s;
    logic              unused_s;

    micro_store #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_store (
        .addr_a (mpc_r),
        .word_a (mir_s),
        .hit_a  (mir_hit_s),
        .addr_b (decode_addr_s),
        .word_b (probe_word_s),
        .hit_b  (probe_hit_s)
    );

    assign cond_s        = cond_e'(mir_s[COND_LSB +: COND_W]);
    assign decode_addr_s = ADDR_W'({1'b1, MSEQ_IR_In[31:30], MSEQ_IR_In[24:19], 2'b00});

`ifdef MSEQ_MEMWAIT_EN
    assign mem_wait_s = (mir_s[RD_BIT] | mir_s[WR_BIT]) & ~MSEQ_MemAck_In;
    assign unused_s   = ^{1'b0, MSEQ_IR_In[29:25], MSEQ_IR_In[18:14], MSEQ_IR_In[12:0],
                          probe_word_s, mir_hit_s};
`else
    assign mem_wait_s = 1'b0;
    assign unused_s   = ^{1'b0, MSEQ_IR_In[29:25], MSEQ_IR_In[18:14], MSEQ_IR_In[12:0],
                          probe_word_s, mir_hit_s, MSEQ_MemAck_In, mir_s[RD_BIT], mir_s[WR_BIT]};
`endif

    assign hold_s = ~MSEQ_Run_In | mem_wait_s;

    // Branch condition evaluated on the current microword
    always_comb begin
        cond_true_s = 1'b0;
        case (cond_s)
            COND_NEXT:   cond_true_s = 1'b0;
            COND_N:      cond_true_s = MSEQ_PSR_In[3];
            COND_Z:      cond_true_s = MSEQ_PSR_In[2];
            COND_V:      cond_true_s = MSEQ_PSR_In[1];
            COND_C:      cond_true_s = MSEQ_PSR_In[0];
            COND_IR13:   cond_true_s = MSEQ_IR_In[13];
            COND_JUMP:   cond_true_s = 1'b1;
            COND_DECODE: cond_true_s = 1'b0;
            default:     cond_true_s = 1'b0;
        endcase
    end

    // Next-address mux; an unpopulated decode target diverts to the trap word
    always_comb begin
        next_mpc_s    = mpc_r + ADDR_W'(1);
        set_illegal_s = 1'b0;
        if (cond_s == COND_DECODE) begin
            if (probe_hit_s) begin
                next_mpc_s = decode_addr_s;
            end else begin
                next_mpc_s    = ADDR_W'(TRAP_ADDR);
                set_illegal_s = 1'b1;
            end
        end else if (cond_true_s) begin
            next_mpc_s = mir_s[ADDR_W-1:0];
        end else begin
            next_mpc_s = mpc_r + ADDR_W'(1);
        end
    end

    // MPC and sticky illegal-opcode registers
    always_ff @(posedge MSEQ_CLOCK_50) begin
        if (!MSEQ_RESET_InLow) begin
            mpc_r     <= ADDR_W'(RESET_ADDR);
            illegal_r <= 1'b0;
        end else if (hold_s) begin
            mpc_r     <= mpc_r;
            illegal_r <= illegal_r;
        end else begin
            mpc_r     <= next_mpc_s;
            illegal_r <= illegal_r | set_illegal_s;
        end
    end

    assign MSEQ_MIR_Out     = mir_s;
    assign MSEQ_MPC_Out     = mpc_r;
    assign MSEQ_Illegal_Out = illegal_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer; honours MSEQ_MEMWAIT_EN when defined.
module tb_micro_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [31:0] ir;
    logic [3:0]  psr;
    logic        ack;
    logic [40:0] mir;
    logic [10:0] mpc;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IR_LD   = 32'h8080_0000; // op=10 op3=010000 -> 1600
    localparam logic [31:0] IR_ST   = 32'hC020_0000; // op=11 op3=000100 -> 1808
    localparam logic [31:0] IR_BAD  = 32'h81F8_0000; // op=10 op3=111111 -> 1788 unpopulated
    localparam logic [31:0] IR_B13  = 32'h0000_2000;

    micro_sequencer dut (
        .MSEQ_CLOCK_50    (clk),
        .MSEQ_RESET_InLow (rst_n),
        .MSEQ_Run_In      (run),
        .MSEQ_IR_In       (ir),
        .MSEQ_PSR_In      (psr),
        .MSEQ_MemAck_In   (ack),
        .MSEQ_MIR_Out     (mir),
        .MSEQ_MPC_Out     (mpc),
        .MSEQ_Illegal_Out (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_mpc(input string tag, input int exp);
        step(1);
        check_eq(tag, 64'(mpc), 64'(exp));
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; ir = 32'd0; psr = 4'd0; ack = 1'b1;
        step(2);
        check_eq("reset_mpc", 64'(mpc), 64'd0);
        check_eq("reset_illegal", 64'(illegal), 64'd0);
        check_eq("reset_mir", 64'(mir), 64'h8_0000);

        rst_n = 1'b1; ir = IR_LD;
        step_mpc("fetch_next", 1);
        step_mpc("decode_ld", 1600);
        step_mpc("ld_next", 1601);

        run = 1'b0;
        step(5);
        check_eq("run_hold", 64'(mpc), 64'd1601);
        run = 1'b1;
        step_mpc("run_resume", 1602);

        psr = 4'b1000;
        step_mpc("cond_n_taken", 20);
        ir = IR_LD | IR_B13;
        step_mpc("jump_8", 8);
        step_mpc("ir13_taken", 12);
        step_mpc("back_to_0", 0);

        ir = IR_ST;
        step_mpc("fetch_st", 1);
        step_mpc("decode_st", 1808);
        step_mpc("st_next", 1809);
        step_mpc("jump_40", 40);
        step(4);
        check_eq("seq_44", 64'(mpc), 64'd44);
        check_eq("mir_44", 64'(mir), 64'h4_37FF);

        ack = 1'b0;
`ifdef MSEQ_MEMWAIT_EN
        step(3);
        check_eq("memwait_hold", 64'(mpc), 64'd44);
        ack = 1'b1;
`endif
        step_mpc("jump_2047", 2047);
        ack = 1'b1;
        step_mpc("wrap_0", 0);

        ir = IR_LD; psr = 4'b0010;
        step_mpc("fetch_2", 1);
        step_mpc("decode_ld2", 1600);
        step(2);
        check_eq("ld2_1602", 64'(mpc), 64'd1602);
        step_mpc("cond_n_not", 1603);
        step_mpc("cond_z_not", 1604);
        step_mpc("cond_v_taken", 20);
        step_mpc("jump_8b", 8);
        step_mpc("ir13_not", 9);
        step_mpc("back_to_0b", 0);

        ir = IR_BAD;
        step_mpc("fetch_bad", 1);
        check_eq("illegal_before", 64'(illegal), 64'd0);
        step_mpc("trap", 2047);
        check_eq("illegal_set", 64'(illegal), 64'd1);
        step_mpc("trap_wrap", 0);
        check_eq("illegal_sticky", 64'(illegal), 64'd1);
        step_mpc("fetch_bad2", 1);

        run = 1'b0;
        step(2);
        check_eq("hold_before_rst", 64'(mpc), 64'd1);
        rst_n = 1'b0;
        step_mpc("rst_during_hold", 0);
        check_eq("rst_clears_illegal", 64'(illegal), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
